// File: rtl/keypad_axil_pkg.sv
// Shared definitions for the keypad AXI4-Lite slave: register word offsets,
// CTRL bit positions, scanner state encoding and the write-strobe merge helper.
// Ports: none (package only).
package keypad_axil_pkg;

  // Word index = byte address [4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_SCAN_DIV = 3'd1;
  localparam logic [2:0] REG_DEBOUNCE = 3'd2;
  localparam logic [2:0] REG_SCRATCH  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_KEY_DATA = 3'd5;

  localparam int CTRL_SCAN_EN = 0;
  localparam int CTRL_IRQ_EN  = 1;

  // Shortest column dwell; the row synchronizer needs settled rows by the sample cycle.
  localparam logic [15:0] KP_MIN_DIV = 16'd4;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_DRIVE = 2'd1,
    SCAN_EVAL  = 2'd2
  } scan_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row synchronizer, column-scan FSM, frame debounce and one-deep code latch.
// Ports: scan_en/scan_div/debounce config in, clr_i read-clear pulse, kp_row_i/kp_col_o pins,
//        key_valid/overrun/key_down/key_code status out.
module keypad_scan
  import keypad_axil_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scan_en_i,
  input  logic [15:0] scan_div_i,
  input  logic [7:0]  debounce_i,
  input  logic        clr_i,
  input  logic [3:0]  kp_row_i,
  output logic [3:0]  kp_col_o,
  output logic        key_valid_o,
  output logic        overrun_o,
  output logic        key_down_o,
  output logic [3:0]  key_code_o
);

  scan_state_t state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  row_s1_q, row_s2_q;
  logic [15:0] frame_q, frame_d;      // bit {row,col} set = key seen pressed
  logic        prev_vld_q, prev_vld_d;
  logic [3:0]  prev_code_q, prev_code_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        key_valid_q, key_valid_d;
  logic        overrun_q, overrun_d;
  logic        key_down_q, key_down_d;
  logic [3:0]  code_q, code_d;

  logic [15:0] div_eff;
  logic [7:0]  deb_eff;
  logic        col_last;
  logic [4:0]  n_keys;
  logic [3:0]  cand_code;
  logic        cand_vld;
  logic        same;

  assign div_eff  = (scan_div_i < KP_MIN_DIV) ? KP_MIN_DIV : scan_div_i;
  assign deb_eff  = (debounce_i == 8'd0) ? 8'd1 : debounce_i;
  // >= so that shrinking SCAN_DIV mid-column ends the column immediately
  assign col_last = (cnt_q >= div_eff - 16'd1);

  always_comb begin
    n_keys    = '0;
    cand_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_q[i]) begin
        n_keys    = n_keys + 5'd1;
        cand_code = 4'(i);
      end
    end
    cand_vld = (n_keys == 5'd1);
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    prev_vld_d  = prev_vld_q;
    prev_code_d = prev_code_q;
    fcnt_d      = fcnt_q;
    // Read-clear applied first so a same-cycle new key is latched as fresh, not as overrun
    key_valid_d = key_valid_q & ~clr_i;
    overrun_d   = overrun_q & ~clr_i;
    key_down_d  = key_down_q;
    code_d      = code_q;
    same        = 1'b0;
    case (state_q)
      SCAN_IDLE: begin
        if (scan_en_i) begin
          state_d = SCAN_DRIVE;
          col_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      SCAN_DRIVE: begin
        if (!col_last) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          frame_d[{2'd0, col_q}] = ~row_s2_q[0];
          frame_d[{2'd1, col_q}] = ~row_s2_q[1];
          frame_d[{2'd2, col_q}] = ~row_s2_q[2];
          frame_d[{2'd3, col_q}] = ~row_s2_q[3];
          if (!scan_en_i)         state_d = SCAN_IDLE;   // partial frame is dropped
          else if (col_q == 2'd3) state_d = SCAN_EVAL;
          else                    col_d   = col_q + 2'd1;
        end
      end
      SCAN_EVAL: begin
        same   = (cand_vld == prev_vld_q) && (!cand_vld || (cand_code == prev_code_q));
        fcnt_d = !same ? 8'd1 : ((fcnt_q == 8'd255) ? 8'd255 : fcnt_q + 8'd1);
        prev_vld_d  = cand_vld;
        prev_code_d = cand_code;
        if (fcnt_d >= deb_eff) begin
          if (cand_vld && !key_down_q) begin
            key_down_d = 1'b1;
            if (key_valid_d) overrun_d = 1'b1;
            else begin
              key_valid_d = 1'b1;
              code_d      = cand_code;
            end
          end else if (!cand_vld) begin
            key_down_d = 1'b0;
          end
        end
        col_d   = 2'd0;
        cnt_d   = '0;
        state_d = scan_en_i ? SCAN_DRIVE : SCAN_IDLE;
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SCAN_IDLE;
      col_q       <= '0;
      cnt_q       <= '0;
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      frame_q     <= '0;
      prev_vld_q  <= 1'b0;
      prev_code_q <= '0;
      fcnt_q      <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      key_down_q  <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      row_s1_q    <= kp_row_i;
      row_s2_q    <= row_s1_q;
      frame_q     <= frame_d;
      prev_vld_q  <= prev_vld_d;
      prev_code_q <= prev_code_d;
      fcnt_q      <= fcnt_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
      key_down_q  <= key_down_d;
      code_q      <= code_d;
    end
  end

  assign kp_col_o    = (state_q == SCAN_DRIVE) ? ~(4'b0001 << col_q) : 4'hF;
  assign key_valid_o = key_valid_q;
  assign overrun_o   = overrun_q;
  assign key_down_o  = key_down_q;
  assign key_code_o  = code_q;

endmodule

// File: rtl/keypad_axil_slave.sv
// AXI4-Lite register slave for the myKEYPAD IP: register file, write/read channel handshakes, irq.
// Ports: s00_axi_* AXI4-Lite slave (OKAY-only responses), kp_row_i/kp_col_o keypad pins,
//        irq_o level interrupt (irq_en & key_valid, registered).
module keypad_axil_slave
  import keypad_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic [3:0]                        kp_row_i,
  output logic [3:0]                        kp_col_o,
  output logic                              irq_o
);

  logic        wr_rdy_q, wr_rdy_d;     // shared awready/wready pulse
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ctrl_q, ctrl_d, div_q, div_d, deb_q, deb_d, scratch_q, scratch_d;
  logic        irq_q, irq_d;

  logic        wr_fire, rd_fire, key_clr;
  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] rd_mux;
  logic        key_valid, overrun, key_down;
  logic [3:0]  key_code;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_idx  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx  = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_fire = wr_rdy_q & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_fire = arready_q & s00_axi_arvalid;
  assign key_clr = rd_fire & (rd_idx == REG_KEY_DATA);

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      REG_CTRL:     rd_mux = ctrl_q;
      REG_SCAN_DIV: rd_mux = div_q;
      REG_DEBOUNCE: rd_mux = deb_q;
      REG_SCRATCH:  rd_mux = scratch_q;
      REG_STATUS:   rd_mux = {29'd0, key_down, overrun, key_valid};
      REG_KEY_DATA: rd_mux = {23'd0, key_valid, 4'd0, key_code};
      default:      rd_mux = '0;
    endcase
  end

  always_comb begin
    // Ready is raised only while no response is pending, so one write is in flight at a time
    wr_rdy_d = ~wr_rdy_q & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
    bvalid_d = bvalid_q;
    if (wr_fire)             bvalid_d = 1'b1;
    else if (s00_axi_bready) bvalid_d = 1'b0;

    ctrl_d    = ctrl_q;
    div_d     = div_q;
    deb_d     = deb_q;
    scratch_d = scratch_q;
    if (wr_fire) begin
      case (wr_idx)
        REG_CTRL:     ctrl_d    = apply_strb(ctrl_q,    s00_axi_wdata, s00_axi_wstrb);
        REG_SCAN_DIV: div_d     = apply_strb(div_q,     s00_axi_wdata, s00_axi_wstrb);
        REG_DEBOUNCE: deb_d     = apply_strb(deb_q,     s00_axi_wdata, s00_axi_wstrb);
        REG_SCRATCH:  scratch_d = apply_strb(scratch_q, s00_axi_wdata, s00_axi_wstrb);
        default: ;
      endcase
    end

    arready_d = ~arready_q & s00_axi_arvalid & ~rvalid_q;
    rvalid_d  = rvalid_q;
    if (rd_fire)             rvalid_d = 1'b1;
    else if (s00_axi_rready) rvalid_d = 1'b0;
    rdata_d = rd_fire ? rd_mux : rdata_q;

    irq_d = ctrl_q[CTRL_IRQ_EN] & key_valid;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_rdy_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      div_q     <= '0;
      deb_q     <= '0;
      scratch_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      wr_rdy_q  <= wr_rdy_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      scratch_q <= scratch_d;
      irq_q     <= irq_d;
    end
  end

  keypad_scan u_scan (
    .clk_i       (s00_axi_aclk),
    .rst_ni      (s00_axi_aresetn),
    .scan_en_i   (ctrl_q[CTRL_SCAN_EN]),
    .scan_div_i  (div_q[15:0]),
    .debounce_i  (deb_q[7:0]),
    .clr_i       (key_clr),
    .kp_row_i    (kp_row_i),
    .kp_col_o    (kp_col_o),
    .key_valid_o (key_valid),
    .overrun_o   (overrun),
    .key_down_o  (key_down),
    .key_code_o  (key_code)
  );

  assign s00_axi_awready = wr_rdy_q;
  assign s00_axi_wready  = wr_rdy_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign irq_o           = irq_q;

endmodule

// File: tb/tb_keypad_axil_slave.sv
// Directed + randomized bench for keypad_axil_slave with a physical keypad model and
// a register/key-latch reference model.
module tb_keypad_axil_slave;

  localparam int FRAME = 33;   // SCAN_DIV=8: 4 columns x 8 cycles + 1 evaluation cycle
  localparam int LIM   = 64;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  kp_row, kp_col;
  logic        irq;
  logic [15:0] pressed;        // bit {row,col}: switch closed

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_reg [4];
  logic        m_kv, m_ov;
  logic [3:0]  m_code;

  always #5 clk = ~clk;

  // A closed switch pulls its row low while its column is driven low
  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++) kp_row[r] = ~|(pressed[r*4 +: 4] & ~kp_col);
  end

  keypad_axil_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .kp_row_i(kp_row), .kp_col_o(kp_col), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic aw_send(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < LIM) begin @(posedge clk); #1; n++; end
    check("aw_w_handshake", {31'd0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic b_wait(output logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < LIM) begin @(posedge clk); #1; n++; end
    check("b_valid", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic ar_send(input logic [4:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < LIM) begin @(posedge clk); #1; n++; end
    check("ar_handshake", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic r_wait(output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    rready = 1'b1;
    while (!rvalid && n < LIM) begin @(posedge clk); #1; n++; end
    check("r_valid", {31'd0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    aw_send(a, d, s);
    b_wait(resp);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  rr;
    ar_send(a);
    r_wait(d, rr);
    check(tag, d, exp);
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  // Hold one key long enough to debounce, then release long enough to clear key_down
  task automatic press_release(input int k);
    pressed = 16'(1 << k);
    wait_frames(8);
    pressed = '0;
    wait_frames(8);
    if (m_kv) m_ov = 1'b1;
    else begin m_kv = 1'b1; m_code = 4'(k); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [4:0]  a5;
    logic [3:0]  s4;
    logic        seen;
    int          k;
    int          n;

    aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1; pressed = '0;
    m_kv = 1'b0; m_ov = 1'b0; m_code = '0;
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    repeat (3) @(posedge clk); #1;

    // Reset state
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_rdata",   rdata,            32'd0);
    check("rst_resp",    {28'd0, bresp, rresp}, 32'd0);
    check("rst_kp_col",  {28'd0, kp_col},  32'h0000000F);
    check("rst_irq",     {31'd0, irq},     32'd0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Byte strobe on SCRATCH from reset value
    wr(5'h0C, 32'hFFFF_FFFF, 4'b0010, resp);
    rd_chk("scratch_wstrb", 5'h0C, 32'h0000_FF00);

    // Basic RW: 1,2,3,4 to the four storage registers
    for (int i = 0; i < 4; i++) begin
      wr(5'(i * 4), 32'(i + 1), 4'hF, resp);
      check("t1_bresp", {30'd0, resp}, 32'd0);
      m_reg[i] = 32'(i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      ar_send(5'(i * 4));
      r_wait(d, resp);
      check("t1_rdata", d, m_reg[i]);
      check("t1_rresp", {30'd0, resp}, 32'd0);
    end

    // Randomized writes with random strobes against the register model
    for (int i = 0; i < 8; i++) begin
      k  = $urandom_range(0, 3);
      d  = $urandom;
      s4 = 4'($urandom_range(0, 15));
      wr(5'(k * 4), d, s4, resp);
      m_reg[k] = merge(m_reg[k], d, s4);
      k = $urandom_range(0, 3);
      rd_chk("rand_reg", 5'(k * 4), m_reg[k]);
    end

    // Read-only and unmapped addresses: writes dropped, OKAY, read zero
    wr(5'h10, $urandom, 4'hF, resp);
    check("ro_bresp", {30'd0, resp}, 32'd0);
    wr(5'h18, $urandom, 4'hF, resp);
    rd_chk("status_idle", 5'h10, 32'd0);
    rd_chk("unmapped_18", 5'h18, 32'd0);
    rd_chk("unmapped_1c", 5'h1C, 32'd0);

    // Single key: row1/col2 -> code 0x6
    wr(5'h00, 32'd3, 4'hF, resp);
    wr(5'h04, 32'd8, 4'hF, resp);
    wr(5'h08, 32'd2, 4'hF, resp);
    pressed = 16'h0040;
    wait_frames(8);
    rd_chk("t3_status", 5'h10, 32'h5);
    check("t3_irq_set", {31'd0, irq}, 32'd1);
    rd_chk("t3_keydata", 5'h14, 32'h106);
    rd_chk("t3_keydata2", 5'h14, 32'h006);
    check("t3_irq_clr", {31'd0, irq}, 32'd0);
    pressed = '0;
    wait_frames(8);
    rd_chk("t3_released", 5'h10, 32'h0);
    m_code = 4'h6;

    // Two presses without a read: first code kept, overrun flagged
    press_release(6);
    press_release(9);
    rd_chk("t4_status", 5'h10, {30'd0, m_ov, m_kv});
    rd_chk("t4_keydata", 5'h14, {23'd0, m_kv, 4'd0, m_code});
    m_kv = 1'b0; m_ov = 1'b0;
    rd_chk("t4_status_clr", 5'h10, 32'h0);

    // Bounce: key toggles every frame, never stable for 3 frames
    wr(5'h08, 32'd3, 4'hF, resp);
    k = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) begin
      pressed = (i % 2 == 1) ? 16'(1 << k) : 16'd0;
      repeat (FRAME) @(posedge clk);
    end
    #1;
    pressed = '0;
    wait_frames(8);
    rd_chk("t5_bounce_status", 5'h10, 32'h0);
    check("t5_bounce_irq", {31'd0, irq}, 32'd0);

    // Random presses with optional reads against the latch model
    for (int i = 0; i < 4; i++) begin
      press_release($urandom_range(0, 15));
      check("rand_irq", {31'd0, irq}, {31'd0, m_kv});
      rd_chk("rand_status", 5'h10, {30'd0, m_ov, m_kv});
      if ($urandom_range(0, 1) == 1) begin
        rd_chk("rand_keydata", 5'h14, {23'd0, m_kv, 4'd0, m_code});
        m_kv = 1'b0; m_ov = 1'b0;
      end
    end
    rd_chk("rand_keydata_end", 5'h14, {23'd0, m_kv, 4'd0, m_code});
    m_kv = 1'b0; m_ov = 1'b0;
    rd_chk("rand_status_end", 5'h10, 32'h0);

    // Write backpressure: no second accept while B is pending
    bready = 1'b0;
    aw_send(5'h0C, 32'hA5A5_0001, 4'hF);
    awaddr = 5'h0C; wdata = 32'h5A5A_0002; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen = seen | awready | wready; end
    check("t6_no_accept", {31'd0, seen}, 32'd0);
    check("t6_bvalid_held", {31'd0, bvalid}, 32'd1);
    b_wait(resp);
    check("t6_bresp1", {30'd0, resp}, 32'd0);
    aw_send(5'h0C, 32'h5A5A_0002, 4'hF);
    b_wait(resp);
    rd_chk("t6_scratch", 5'h0C, 32'h5A5A_0002);

    // Reset while a read response is outstanding
    rready = 1'b0;
    ar_send(5'h0C);
    n = 0;
    while (!rvalid && n < LIM) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk); #1;
    check("t6_rvalid_held", {31'd0, rvalid}, 32'd1);
    check("t6_rdata_held", rdata, 32'h5A5A_0002);
    aresetn = 1'b0;
    #1;
    check("t6_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("t6_rst_rdata", rdata, 32'd0);
    check("t6_rst_kp_col", {28'd0, kp_col}, 32'h0000000F);
    @(posedge clk); #1;
    aresetn = 1'b1;
    rready = 1'b1;
    @(posedge clk); #1;
    rd_chk("t6_ctrl_after_rst", 5'h00, 32'd0);
    rd_chk("t6_scratch_after_rst", 5'h0C, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
